// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between the execute path (0) and the CSR unit (1).
module alu_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 5,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [1:0]                 i_req_valid,
  output logic [1:0]                 o_req_ready,
  input  logic [2*CONTROL_WIDTH-1:0] i_req_alu_control,
  input  logic [2*DATA_WIDTH-1:0]    i_req_src_1,
  input  logic [2*DATA_WIDTH-1:0]    i_req_src_2,
  output logic [1:0]                 o_rsp_valid,
  input  logic [1:0]                 i_rsp_ready,
  output logic [DATA_WIDTH-1:0]      o_rsp_result,
  output logic                       o_rsp_zero_flag,
  output logic                       o_rsp_slt_flag,
  output logic                       o_rsp_sltu_flag,
  output logic [CONTROL_WIDTH-1:0]   o_alu_control,
  output logic [DATA_WIDTH-1:0]      o_alu_src_1,
  output logic [DATA_WIDTH-1:0]      o_alu_src_2,
  input  logic [DATA_WIDTH-1:0]      i_alu_result,
  input  logic                       i_alu_zero_flag,
  input  logic                       i_alu_slt_flag,
  input  logic                       i_alu_sltu_flag,
  output logic                       o_busy,
  output logic [COUNT_WIDTH-1:0]     o_op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                   state_q;
  logic                     rr_q, gnt_q, sel_d;
  logic [DATA_WIDTH-1:0]    rsp_result_q;
  logic                     rsp_zero_q, rsp_slt_q, rsp_sltu_q;
  logic [CONTROL_WIDTH-1:0] alu_control_q;
  logic [DATA_WIDTH-1:0]    alu_src_1_q, alu_src_2_q;
  logic [COUNT_WIDTH-1:0]   op_count_q;
  // Ready is gated by arstn so every output reads 0 while reset is held.
  always_comb begin
    o_req_ready = '0;
    if (state_q == IDLE && arstn)
      o_req_ready = (i_req_valid == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : i_req_valid;
    sel_d = o_req_ready[1];
  end
  assign o_rsp_valid     = {state_q == RESP && gnt_q, state_q == RESP && !gnt_q};
  assign o_busy          = state_q != IDLE;
  assign o_rsp_result    = rsp_result_q;
  assign o_rsp_zero_flag = rsp_zero_q;
  assign o_rsp_slt_flag  = rsp_slt_q;
  assign o_rsp_sltu_flag = rsp_sltu_q;
  assign o_alu_control   = alu_control_q;
  assign o_alu_src_1     = alu_src_1_q;
  assign o_alu_src_2     = alu_src_2_q;
  assign o_op_count      = op_count_q;
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      gnt_q         <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_slt_q     <= 1'b0;
      rsp_sltu_q    <= 1'b0;
      alu_control_q <= '0;
      alu_src_1_q   <= '0;
      alu_src_2_q   <= '0;
      op_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|o_req_ready) begin
          alu_control_q <= sel_d ? i_req_alu_control[2*CONTROL_WIDTH-1:CONTROL_WIDTH] : i_req_alu_control[CONTROL_WIDTH-1:0];
          alu_src_1_q   <= sel_d ? i_req_src_1[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_src_1[DATA_WIDTH-1:0];
          alu_src_2_q   <= sel_d ? i_req_src_2[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_src_2[DATA_WIDTH-1:0];
          gnt_q         <= sel_d;
          rr_q          <= ~sel_d;
          state_q       <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= i_alu_result;
          rsp_zero_q   <= i_alu_zero_flag;
          rsp_slt_q    <= i_alu_slt_flag;
          rsp_sltu_q   <= i_alu_sltu_flag;
          state_q      <= RESP;
        end
        RESP: if (i_rsp_ready[gnt_q]) begin
          op_count_q <= op_count_q + 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one alu instance between two requesters: requester 0 is the integer execute path and requester 1 is the CSR/system unit. Grants are round-robin. The block registers the granted operands, drives the shared ALU for one cycle, captures the result and flags, and holds a response for the granted requester until that requester accepts it. It sits between the requesters and the alu instance; the ALU itself stays purely combinational.

Parameters:
DATA_WIDTH, 64, operand/result width; matches alu DATA_WIDTH.
CONTROL_WIDTH, 5, ALU opcode width; matches alu CONTROL_WIDTH.
COUNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge.
arstn  input  1  asynchronous active-low reset.
i_req_valid  input  2  bit k: requester k presents an operation.
o_req_ready  output  2  bit k: operation from requester k is accepted this cycle.
i_req_alu_control  input  2*CONTROL_WIDTH  opcode of requester k in slice [k*CONTROL_WIDTH +: CONTROL_WIDTH].
i_req_src_1  input  2*DATA_WIDTH  operand 1 of requester k in slice [k*DATA_WIDTH +: DATA_WIDTH].
i_req_src_2  input  2*DATA_WIDTH  operand 2 of requester k, same slicing.
o_rsp_valid  output  2  bit k: response for requester k is available.
i_rsp_ready  input  2  bit k: requester k accepts the response.
o_rsp_result  output  DATA_WIDTH  captured ALU result.
o_rsp_zero_flag  output  1  captured zero flag.
o_rsp_slt_flag  output  1  captured signed less-than flag.
o_rsp_sltu_flag  output  1  captured unsigned less-than flag.
o_alu_control  output  CONTROL_WIDTH  opcode to the shared ALU.
o_alu_src_1  output  DATA_WIDTH  operand 1 to the shared ALU.
o_alu_src_2  output  DATA_WIDTH  operand 2 to the shared ALU.
i_alu_result  input  DATA_WIDTH  ALU result.
i_alu_zero_flag, i_alu_slt_flag, i_alu_sltu_flag  input  1 each  ALU flags.
o_busy  output  1  high whenever the FSM is not in IDLE.
o_op_count  output  COUNT_WIDTH  count of completed response handshakes.

Behaviour:
- Reset: arstn low immediately forces the following, regardless of clock:
  - FSM to IDLE;
  - all outputs to 0 (o_req_ready, o_rsp_valid, o_rsp_result, all o_rsp flags, o_alu_control, o_alu_src_1/2, o_busy, o_op_count);
  - round-robin pointer to "requester 0 has priority";
  - grant id register to 0.
- A reset in EXEC or RESP discards the in-flight operation; no response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready is combinational. Only one requester valid: that bit is ready. Both valid: the bit selected by the round-robin pointer is ready. Neither valid: o_req_ready = 00.
  - At most one bit of o_req_ready is ever high.
  - On valid&ready at a clock edge: latch that requester's opcode and operands into o_alu_control/o_alu_src_1/o_alu_src_2; latch the grant id; point the round-robin pointer at the other requester; go to EXEC.
- EXEC: registered operands drive the ALU for exactly one cycle. At the clock edge, capture i_alu_result and the three flags into the o_rsp_* registers, then go to RESP. o_req_ready = 00.
- RESP:
  - o_rsp_valid[grant id] = 1; the other bit = 0. o_req_ready = 00.
  - o_rsp_result and the o_rsp flags stay stable until the handshake.
  - On o_rsp_valid[k] & i_rsp_ready[k]: o_op_count increments (wraps modulo 2^COUNT_WIDTH), then go to IDLE.
  - i_rsp_ready from the non-granted requester is ignored.
- Latency and throughput:
  - Accept edge at cycle N, EXEC in cycle N+1, o_rsp_valid high in cycle N+2.
  - With i_rsp_ready held high, the response completes at the N+2 edge. The next accept can be in cycle N+3, so throughput is one op per 3 cycles.
- The pointer updates only on an accept. A requester that drops valid before being granted loses nothing and changes no state.
- o_alu_* registers hold their last value outside EXEC.
- Opcodes are passed through unchecked. An undefined opcode (e.g. 5'b11111) completes normally with the ALU's 0 result and zero flag = 1.
- Requesters must hold valid and operands stable until ready; the arbiter does not check this.

Test Plan:
- Single op: after reset, requester 0 sends ADD (5'b00000), src_1 = 5, src_2 = 7, i_rsp_ready = 1 -> o_req_ready = 01 in the accept cycle; o_rsp_valid = 01 two cycles later; result = 12, zero = 0; o_op_count = 1.
- Contention: both requesters valid continuously; req0 sends SUB 3-3, req1 sends SLT with src_1 = -1, src_2 = 1 -> req0 served first (result 0, zero = 1), then req1 (result 1, slt = 1, sltu = 0). Grants alternate 0,1,0,1 over 4 ops; never two ready bits high at once.
- Backpressure: req1 sends CSRRC with src_1 = 0x0F, src_2 = 0xFF and holds i_rsp_ready = 0 for 4 cycles -> o_rsp_valid = 10, result = 0xF0 stable throughout; o_req_ready = 00 even though req0 is valid; completes the cycle after ready rises.
- Wrong-requester ready: in RESP for req0, assert i_rsp_ready = 10 -> no completion; o_op_count unchanged.
- Reset mid-op: assert arstn low during EXEC -> all outputs 0 immediately; after release, no o_rsp_valid appears for the dropped op; the next contention grants req0.
- Counter wrap: with COUNT_WIDTH = 4, complete 17 ops -> o_op_count reads 15, then 0, then 1.
